imem_dmem_port_arbiter: RTL and testbench
=========================================

# imem_dmem_port_arbiter

Sequences the single-ported unified memory shared by the fetch stage and the memory stage of the rv32i pipeline. It owns one outstanding memory transaction at a time, chooses between the fetch request (driven by `PCF`) and the load/store request, and produces `stallF`/`stallM` back to the hazard logic. It discards fetch responses that belong to a flushed fetch, and bounds fetch starvation under back-to-back data traffic.

## Interface
- `DPW`, 32: address/data width (from `rv32i_pkg`).
- `MAX_DSTREAK`, 4: number of consecutive data grants allowed while fetch waits. Range 1..15.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `flushF`  in  1  fetch flush from the hazard unit.
- `if_req`  in  1  fetch wants the word at `if_addr`; held until `if_valid`, or until dropped by a flush.
- `if_addr`  in  DPW  fetch address (`PCF`).
- `if_valid`  out  1  one-cycle pulse: `if_rdata` is valid.
- `if_rdata`  out  DPW  instruction word.
- `stallF`  out  1  `if_req & ~if_valid`.
- `d_req`, `d_we`  in  1  data request and write enable; held until `d_valid`.
- `d_addr`, `d_wdata`  in  DPW  data address and store data.
- `d_be`  in  4  byte enables for the store.
- `d_valid`  out  1  one-cycle pulse: load data valid / store done.
- `d_rdata`  out  DPW  load data.
- `stallM`  out  1  `d_req & ~d_valid`.
- `mem_req`, `mem_we`  out  1  memory request and write enable.
- `mem_addr`, `mem_wdata`  out  DPW  registered address and write data.
- `mem_be`  out  4  registered byte enables (4'hF for fetch).
- `mem_gnt`  in  1  memory accepted the request this cycle.
- `mem_rvalid`, `mem_rdata`  in  1/DPW  response. Arrives at least 1 cycle after `mem_gnt`. Writes are also acknowledged with `mem_rvalid`.

## Operation
- FSM states: IDLE, REQ, WAIT. Registers: `owner` (FETCH/DATA), `kill`, `dstreak` (4 bits).
- IDLE arbitration:
  - Fetch is eligible when `if_req & ~flushF`. Data is eligible when `d_req`.
  - Default priority goes to data (the older instruction).
  - Fetch wins instead when fetch is eligible and `dstreak == MAX_DSTREAK`.
  - On a win, latch addr/wdata/be/we into the `mem_*` registers, set `owner`, clear `kill`, and go to REQ.
  - With no eligible requester, stay in IDLE.
- `dstreak` update at each grant:
  - Data grant with `if_req` high: `dstreak += 1`, saturating at `MAX_DSTREAK`.
  - Fetch grant, or data grant with `if_req` low: `dstreak = 0`.
- REQ: `mem_req = 1` with stable `mem_*` outputs. Go to WAIT on `mem_gnt`. The request is never withdrawn, including on a flush.
- WAIT: `mem_req = 0`. On `mem_rvalid`:
  - Owner DATA: pulse `d_valid` with `d_rdata = mem_rdata`.
  - Owner FETCH with `kill = 0`: pulse `if_valid` with `if_rdata = mem_rdata`.
  - Owner FETCH with `kill = 1`: no pulse; the response is discarded.
  - In every case, go to IDLE.
- `kill` is set when `flushF` is high while `owner == FETCH` in REQ or WAIT. It is cleared on entry to REQ.
- `mem_rvalid` in IDLE or REQ is ignored (no pulse, no state change).
- `if_valid` and `d_valid` are combinational from `mem_rvalid` and state. They are never high together.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `if_valid`, `d_valid`, `kill` = 0; `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0; `mem_be` = 0; `dstreak` = 0.
- Reset asserted mid-transaction: return to IDLE immediately and drop `mem_req` asynchronously. Any later `mem_rvalid` is ignored.
- Best-case latency: request seen in IDLE at cycle 0 → `mem_req` at cycle 1 → `mem_gnt` at cycle 1 → `mem_rvalid` at cycle 2 → `*_valid` at cycle 2 → IDLE at cycle 3. This gives one transaction per 3 cycles at best.
- `stallF` and `stallM` are combinational and drop in the same cycle as their valid pulse.
- `flushF` in the same cycle as a fetch win in IDLE: fetch is not granted that cycle.
- `flushF` in the same cycle as `mem_rvalid` for a fetch in WAIT: the response is discarded and `if_valid` stays 0.

## Test plan
- Fetch only: `if_addr = 0x100`; `mem_gnt` at cycle 1; `mem_rvalid` at cycle 3 with `0x00500093` → `if_valid` at cycle 3 with `if_rdata = 0x00500093`; `stallF` high in cycles 0–2, low at cycle 3.
- Simultaneous requests: `if_req` (0x104) and a load `d_req` (0x2000) at cycle 0 → data granted first (`mem_addr = 0x2000`, `mem_we = 0`), `d_valid` returns; then fetch is granted with `mem_addr = 0x104`.
- Store: `d_we = 1`, `d_be = 4'b0011`, `d_wdata = 0xDEADBEEF` → `mem_we = 1`, `mem_be = 0011`, `mem_wdata = 0xDEADBEEF`; `d_valid` on the `mem_rvalid` ack.
- Starvation bound: `d_req` held continuously with `if_req` high and `MAX_DSTREAK = 4` → exactly 4 data grants, then 1 fetch grant, then `dstreak = 0`.
- Flush in flight: fetch of 0x108 in WAIT; `flushF` pulse → response 0x12345678 is discarded (`if_valid` stays 0) and `stallF` stays high; the next fetch of 0x0 completes normally.
- Reset mid-REQ: `rst_n` low while `mem_req = 1` → `mem_req` drops immediately and state is IDLE; a stray `mem_rvalid` after reset produces no valid pulse.

Source files
------------

// File: rtl/imem_dmem_port_arbiter.sv
// imem_dmem_port_arbiter
// Sequences the single-ported unified memory shared by instruction fetch and
// the load/store stage. Exactly one memory transaction is in flight at a time.
// Data requests win by default (older instruction), but fetch is forced in
// after MAX_DSTREAK consecutive data grants taken while fetch was waiting.
// A fetch flushed while in flight is still completed on the memory side, but
// its response is swallowed so the pipeline never sees a stale instruction.
//
// state | meaning
// IDLE  | nothing in flight; arbitrate between fetch and data
// REQ   | mem_req held high with stable mem_* until mem_gnt
// WAIT  | request accepted; waiting for mem_rvalid to route to the owner
module imem_dmem_port_arbiter #(
    parameter int DPW         = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flushF,
    input  logic           if_req,
    input  logic [DPW-1:0] if_addr,
    output logic           if_valid,
    output logic [DPW-1:0] if_rdata,
    output logic           stallF,
    input  logic           d_req,
    input  logic           d_we,
    input  logic [DPW-1:0] d_addr,
    input  logic [DPW-1:0] d_wdata,
    input  logic [3:0]     d_be,
    output logic           d_valid,
    output logic [DPW-1:0] d_rdata,
    output logic           stallM,
    output logic           mem_req,
    output logic           mem_we,
    output logic [DPW-1:0] mem_addr,
    output logic [DPW-1:0] mem_wdata,
    output logic [3:0]     mem_be,
    input  logic           mem_gnt,
    input  logic           mem_rvalid,
    input  logic [DPW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    state_t     state;
    owner_t     owner;
    logic       kill;
    logic [3:0] dstreak;

    logic       fetch_elig;
    logic       data_elig;
    logic       streak_full;
    logic       fetch_win;
    logic       data_win;
    logic       rsp;
    logic       fetch_flushed;
    logic [3:0] dstreak_after_data;

    // Arbitration, response routing and stall generation (all combinational).
    always_comb begin
        fetch_elig    = if_req & ~flushF;
        data_elig     = d_req;
        streak_full   = (dstreak == STREAK_MAX);
        // Fetch only wins when data is absent or the starvation bound is hit.
        fetch_win     = fetch_elig & (~data_elig | streak_full);
        data_win      = data_elig & ~fetch_win;

        // Streak counts only data grants that actually made fetch wait.
        if (!if_req) begin
            dstreak_after_data = 4'd0;
        end else if (streak_full) begin
            dstreak_after_data = STREAK_MAX;
        end else begin
            dstreak_after_data = dstreak + 4'd1;
        end

        fetch_flushed = flushF & (owner == FETCH) & ((state == REQ) | (state == WAIT));

        rsp = (state == WAIT) & mem_rvalid;
        // A flush arriving together with the response must also suppress it.
        if_valid = rsp & (owner == FETCH) & ~kill & ~flushF;
        d_valid  = rsp & (owner == DATA);

        if_rdata = if_valid ? mem_rdata : '0;
        d_rdata  = d_valid  ? mem_rdata : '0;

        stallF = if_req & ~if_valid;
        stallM = d_req  & ~d_valid;
    end

    // Transaction FSM with registered memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= FETCH;
            kill      <= 1'b0;
            dstreak   <= 4'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_win) begin
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= 4'hF;
                        mem_we    <= 1'b0;
                        owner     <= FETCH;
                        kill      <= 1'b0;
                        dstreak   <= 4'd0;
                        mem_req   <= 1'b1;
                        state     <= REQ;
                    end else if (data_win) begin
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                        mem_we    <= d_we;
                        owner     <= DATA;
                        kill      <= 1'b0;
                        dstreak   <= dstreak_after_data;
                        mem_req   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // The request is never withdrawn; a flush only marks it dead.
                    if (fetch_flushed) begin
                        kill <= 1'b1;
                    end
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (fetch_flushed) begin
                        kill <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Bench for imem_dmem_port_arbiter: a table of single transactions, hand
// sequences for priority, starvation, flush and reset, then a randomized run
// checked against a transaction-level model of the memory port.
module tb_imem_dmem_port_arbiter;

    localparam int DPW         = 32;
    localparam int MAX_DSTREAK = 4;

    logic           clk;
    logic           rst_n;
    logic           flushF;
    logic           if_req;
    logic [DPW-1:0] if_addr;
    logic           if_valid;
    logic [DPW-1:0] if_rdata;
    logic           stallF;
    logic           d_req;
    logic           d_we;
    logic [DPW-1:0] d_addr;
    logic [DPW-1:0] d_wdata;
    logic [3:0]     d_be;
    logic           d_valid;
    logic [DPW-1:0] d_rdata;
    logic           stallM;
    logic           mem_req;
    logic           mem_we;
    logic [DPW-1:0] mem_addr;
    logic [DPW-1:0] mem_wdata;
    logic [3:0]     mem_be;
    logic           mem_gnt;
    logic           mem_rvalid;
    logic [DPW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    imem_dmem_port_arbiter #(.DPW(DPW), .MAX_DSTREAK(MAX_DSTREAK)) dut (
        .clk(clk), .rst_n(rst_n), .flushF(flushF),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid),
        .if_rdata(if_rdata), .stallF(stallF),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_valid(d_valid), .d_rdata(d_rdata), .stallM(stallM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        bit          exp_we;
    } vec_t;

    vec_t vecs[5];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // From a REQ cycle: grant, then respond, checking which side gets the pulse.
    task automatic complete(input logic [31:0] rdata, input bit exp_if, input bit exp_d,
                            input bit drop_if, input bit drop_d, input string tag);
        mem_gnt = 1'b1;
        settle();
        chk1({tag, "_req"}, mem_req, 1'b1);
        tick();
        mem_gnt = 1'b0;
        settle();
        chk1({tag, "_req_drop"}, mem_req, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        settle();
        chk1({tag, "_ifv"}, if_valid, exp_if);
        chk1({tag, "_dv"}, d_valid, exp_d);
        if (exp_if) chk32({tag, "_if_rdata"}, if_rdata, rdata);
        if (exp_d) chk32({tag, "_d_rdata"}, d_rdata, rdata);
        if (drop_if) if_req = 1'b0;
        if (drop_d) d_req = 1'b0;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    // Single isolated transaction from the table.
    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        if (v.fetch) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            d_req   = 1'b1;
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
            d_be    = v.be;
        end
        settle();
        chk1({t, "_stall0"}, v.fetch ? stallF : stallM, 1'b1);
        chk1({t, "_idle_req"}, mem_req, 1'b0);
        tick();
        settle();
        chk1({t, "_mem_req"}, mem_req, 1'b1);
        chk32({t, "_mem_addr"}, mem_addr, v.exp_addr);
        chk1({t, "_mem_we"}, mem_we, v.exp_we);
        chk32({t, "_mem_be"}, {28'd0, mem_be}, {28'd0, v.exp_be});
        if (!v.fetch) chk32({t, "_mem_wdata"}, mem_wdata, v.exp_wdata);
        for (int i = 0; i < v.gnt_dly; i++) begin
            tick();
            settle();
            chk1({t, "_req_hold"}, mem_req, 1'b1);
            chk32({t, "_addr_hold"}, mem_addr, v.exp_addr);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < v.rv_dly; i++) begin
            settle();
            chk1({t, "_wait_req"}, mem_req, 1'b0);
            chk1({t, "_wait_valid"}, v.fetch ? if_valid : d_valid, 1'b0);
            chk1({t, "_wait_stall"}, v.fetch ? stallF : stallM, 1'b1);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        settle();
        chk1({t, "_valid"}, v.fetch ? if_valid : d_valid, 1'b1);
        chk1({t, "_other_valid"}, v.fetch ? d_valid : if_valid, 1'b0);
        chk32({t, "_rdata"}, v.fetch ? if_rdata : d_rdata, v.rdata);
        chk1({t, "_stall_drop"}, v.fetch ? stallF : stallM, 1'b0);
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        settle();
    endtask

    // Transaction-level reference model for the random run.
    bit          fetch_pend;
    bit          data_pend;
    int          phase;          // 0 free, 1 requesting, 2 awaiting response
    int          streak;
    bit          t_fetch;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [3:0]  t_be;
    bit          t_we;
    bit          t_kill;

    initial begin
        bit exp_fetch;
        int dcount;
        rst_n      = 1'b0;
        flushF     = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        d_be       = 4'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'h0050_0093, 0, 1,
                    32'h0000_0100, 32'h0, 4'hF, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1, 0,
                    32'h0000_2004, 32'hDEAD_BEEF, 4'b0011, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_2008, 32'h0, 4'hF, 32'h1122_3344, 2, 2,
                    32'h0000_2008, 32'h0, 4'hF, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 32'h0000_006F, 0, 0,
                    32'hFFFF_FFFC, 32'h0, 4'hF, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0102_0304, 4'b1000, 32'h0, 0, 3,
                    32'h0000_0003, 32'h0102_0304, 4'b1000, 1'b1};

        // Reset state.
        tick();
        tick();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_mem_be", {28'd0, mem_be}, 32'h0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk1("rst_d_valid", d_valid, 1'b0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // Table of isolated transactions.
        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Simultaneous fetch and load: data first, then fetch.
        if_req  = 1'b1;
        if_addr = 32'h0000_0104;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_be    = 4'hF;
        d_addr  = 32'h0000_2000;
        settle();
        tick();
        settle();
        chk32("simul_first_addr", mem_addr, 32'h0000_2000);
        chk1("simul_first_we", mem_we, 1'b0);
        complete(32'hCAFE_0001, 1'b0, 1'b1, 1'b0, 1'b1, "simul_d");
        settle();
        chk1("simul_stallF_held", stallF, 1'b1);
        tick();
        settle();
        chk32("simul_second_addr", mem_addr, 32'h0000_0104);
        chk32("simul_second_be", {28'd0, mem_be}, 32'h0000_000F);
        complete(32'h0000_0013, 1'b1, 1'b0, 1'b1, 1'b0, "simul_f");

        // Starvation bound: streak starts at 0 here.
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_3000;
        dcount  = 0;
        for (int i = 0; i < 10; i++) begin
            exp_fetch = (dcount == MAX_DSTREAK);
            if (exp_fetch) dcount = 0;
            else dcount++;
            settle();
            tick();
            settle();
            chk32($sformatf("starve_grant%0d", i), mem_addr,
                  exp_fetch ? 32'h0000_0300 : 32'h0000_3000);
            complete(32'h100 + i, exp_fetch, !exp_fetch, 1'b0, 1'b0,
                     $sformatf("starve%0d", i));
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        settle();
        tick();

        // Flush while the fetch is in WAIT: response discarded, next fetch fine.
        if_req  = 1'b1;
        if_addr = 32'h0000_0108;
        settle();
        tick();
        mem_gnt = 1'b1;
        settle();
        tick();
        mem_gnt = 1'b0;
        flushF  = 1'b1;
        if_addr = 32'h0000_0000;
        settle();
        chk1("flush_stallF", stallF, 1'b1);
        tick();
        flushF     = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        settle();
        chk1("flush_discard_ifv", if_valid, 1'b0);
        chk1("flush_discard_stallF", stallF, 1'b1);
        tick();
        mem_rvalid = 1'b0;
        settle();
        tick();
        settle();
        chk1("flush_refetch_req", mem_req, 1'b1);
        chk32("flush_refetch_addr", mem_addr, 32'h0);
        complete(32'h0000_0013, 1'b1, 1'b0, 1'b1, 1'b0, "refetch");

        // Flush coinciding with the fetch response.
        if_req  = 1'b1;
        if_addr = 32'h0000_010C;
        settle();
        tick();
        mem_gnt = 1'b1;
        settle();
        tick();
        mem_gnt    = 1'b0;
        flushF     = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hAAAA_5555;
        settle();
        chk1("flush_same_cycle_ifv", if_valid, 1'b0);
        chk1("flush_same_cycle_stallF", stallF, 1'b1);
        tick();
        flushF     = 1'b0;
        mem_rvalid = 1'b0;
        if_req     = 1'b0;
        settle();
        tick();
        settle();
        chk1("flush_same_cycle_idle", mem_req, 1'b0);

        // Flush in IDLE blocks the fetch grant.
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        flushF  = 1'b1;
        settle();
        tick();
        flushF = 1'b0;
        if_req = 1'b0;
        settle();
        chk1("flush_idle_no_grant", mem_req, 1'b0);
        tick();

        // Reset in the middle of REQ.
        if_req  = 1'b1;
        if_addr = 32'h0000_0400;
        settle();
        tick();
        settle();
        chk1("rstmid_req_up", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rstmid_req_async_drop", mem_req, 1'b0);
        if_req = 1'b0;
        tick();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0055;
        settle();
        chk1("rstmid_stray_ifv", if_valid, 1'b0);
        chk1("rstmid_stray_dv", d_valid, 1'b0);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk1("rstmid_idle", mem_req, 1'b0);

        // Fresh reset so the model starts from a known streak.
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        fetch_pend = 1'b0;
        data_pend  = 1'b0;
        phase      = 0;
        streak     = 0;
        t_kill     = 1'b0;
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bit exp_ifv, exp_dv, rsp, fetch_ok;
            if (!fetch_pend && $urandom_range(0, 2) == 0) begin
                fetch_pend = 1'b1;
                if_addr    = $urandom & 32'hFFFF_FFFC;
            end
            if (!data_pend && $urandom_range(0, 2) == 0) begin
                data_pend = 1'b1;
                d_we      = ($urandom_range(0, 1) == 1);
                d_addr    = $urandom;
                d_wdata   = $urandom;
                d_be      = 4'($urandom_range(0, 15));
            end
            if_req = fetch_pend;
            d_req  = data_pend;
            flushF = ($urandom_range(0, 7) == 0);
            if (flushF && fetch_pend && $urandom_range(0, 1) == 1)
                if_addr = $urandom & 32'hFFFF_FFFC;
            mem_gnt    = (phase == 1) && ($urandom_range(0, 1) == 1);
            mem_rvalid = (phase == 2) ? ($urandom_range(0, 4) < 2)
                                      : ($urandom_range(0, 9) == 0);
            mem_rdata  = $urandom;
            settle();

            rsp     = (phase == 2) && mem_rvalid;
            exp_ifv = rsp && t_fetch && !t_kill && !flushF;
            exp_dv  = rsp && !t_fetch;
            chk1("rnd_mem_req", mem_req, phase == 1);
            if (phase == 1) begin
                chk32("rnd_mem_addr", mem_addr, t_addr);
                chk1("rnd_mem_we", mem_we, t_we);
                chk32("rnd_mem_be", {28'd0, mem_be}, {28'd0, t_be});
                if (!t_fetch) chk32("rnd_mem_wdata", mem_wdata, t_wdata);
            end
            chk1("rnd_if_valid", if_valid, exp_ifv);
            chk1("rnd_d_valid", d_valid, exp_dv);
            chk1("rnd_stallF", stallF, fetch_pend && !exp_ifv);
            chk1("rnd_stallM", stallM, data_pend && !exp_dv);
            if (exp_ifv) chk32("rnd_if_rdata", if_rdata, mem_rdata);
            if (exp_dv) chk32("rnd_d_rdata", d_rdata, mem_rdata);

            if (phase == 0) begin
                fetch_ok = fetch_pend && !flushF;
                if (data_pend && !(fetch_ok && streak == MAX_DSTREAK)) begin
                    t_fetch = 1'b0;
                    t_addr  = d_addr;
                    t_wdata = d_wdata;
                    t_be    = d_be;
                    t_we    = d_we;
                    t_kill  = 1'b0;
                    streak  = fetch_pend ? ((streak < MAX_DSTREAK) ? streak + 1 : MAX_DSTREAK) : 0;
                    phase   = 1;
                end else if (fetch_ok) begin
                    t_fetch = 1'b1;
                    t_addr  = if_addr;
                    t_be    = 4'hF;
                    t_we    = 1'b0;
                    t_kill  = 1'b0;
                    streak  = 0;
                    phase   = 1;
                end
            end else begin
                if (flushF && t_fetch) t_kill = 1'b1;
                if (phase == 1 && mem_gnt) phase = 2;
                else if (phase == 2 && mem_rvalid) begin
                    phase = 0;
                    if (exp_ifv) fetch_pend = 1'b0;
                    if (exp_dv) data_pend = 1'b0;
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
